// File: rtl/torstencc_drain_pkg.sv
// Shared pin map and types for the strobed byte adder with result FIFO.
package torstencc_drain_pkg;

  localparam int WR_STROBE_BIT = 0;
  localparam int RD_ACK_BIT    = 1;
  localparam int VALID_BIT     = 2;
  localparam int FULL_BIT      = 3;
  localparam int OVF_BIT       = 4;
  localparam int CARRY_BIT     = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'b0011_1100;

  typedef enum logic {PH_A, PH_B} phase_t;

endpackage

// File: rtl/torstencc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector that emits a single-cycle event.
module torstencc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign event_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_um_torstencc_sum_drain.sv
// Strobed A/B byte capture, registered 9-bit sum, and a small result FIFO
// drained over a valid/ack handshake on the bidirectional pins.
module tt_um_torstencc_sum_drain
  import torstencc_drain_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic wr_ev, rd_ev;

  phase_t     phase_q, phase_d;
  logic [7:0] a_q, a_d;
  logic [8:0] sum_q, sum_d;
  logic       sum_vld_q, sum_vld_d;

  logic [8:0]       mem_q [DEPTH];
  logic [8:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic is_full, is_empty, pop, push_ok;
  logic unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7:2]};

  torstencc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[WR_STROBE_BIT]),
    .event_o  (wr_ev)
  );

  torstencc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[RD_ACK_BIT]),
    .event_o  (rd_ev)
  );

  always_comb begin
    phase_d   = phase_q;
    a_d       = a_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    case (phase_q)
      PH_A: if (wr_ev) begin
        a_d     = ui_in;
        phase_d = PH_B;
      end
      PH_B: if (wr_ev) begin
        sum_d     = {1'b0, a_q} + {1'b0, ui_in};
        sum_vld_d = 1'b1;
        phase_d   = PH_A;
      end
      default: phase_d = PH_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_A;
      a_q       <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      a_q       <= a_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
    end
  end

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);
  assign pop      = rd_ev && !is_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = sum_vld_q && (!is_full || pop);

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[tail_q] = sum_q;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    if (sum_vld_q && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    uo_out                = is_empty ? 8'h00 : mem_q[head_q][7:0];
    uio_out               = 8'h00;
    uio_out[VALID_BIT]    = !is_empty;
    uio_out[FULL_BIT]     = is_full;
    uio_out[OVF_BIT]      = overflow_q;
    uio_out[CARRY_BIT]    = is_empty ? 1'b0 : mem_q[head_q][8];
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_torstencc_sum_drain.sv
// Directed, table-driven bench for the strobed adder with result FIFO.
module tb_tt_um_torstencc_sum_drain;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic       wr_strobe;
  logic       rd_ack;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int num_checks;
  int num_errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_uo;
    logic       exp_carry;
  } vec_t;

  vec_t vectors[6];

  assign uio_in = {6'b0, rd_ack, wr_strobe};

  tt_um_torstencc_sum_drain dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Strobe a byte in and wait long enough for the result to reach the FIFO head.
  task automatic write_byte(input logic [7:0] b);
    ui_in = b;
    @(negedge clk);
    wr_strobe = 1'b1;
    repeat (4) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_read();
    rd_ack = 1'b1;
    repeat (4) @(negedge clk);
    rd_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    write_byte(a);
    write_byte(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    ui_in      = 8'h00;
    wr_strobe  = 1'b0;
    rd_ack     = 1'b0;
    rst_n      = 1'b0;

    vectors[0] = '{a: 8'h12, b: 8'h34, exp_uo: 8'h46, exp_carry: 1'b0};
    vectors[1] = '{a: 8'hFF, b: 8'h02, exp_uo: 8'h01, exp_carry: 1'b1};
    vectors[2] = '{a: 8'hFF, b: 8'hFF, exp_uo: 8'hFE, exp_carry: 1'b1};
    vectors[3] = '{a: 8'h00, b: 8'h00, exp_uo: 8'h00, exp_carry: 1'b0};
    vectors[4] = '{a: 8'h80, b: 8'h80, exp_uo: 8'h00, exp_carry: 1'b1};
    vectors[5] = '{a: 8'h7F, b: 8'h01, exp_uo: 8'h80, exp_carry: 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_uo_out", {1'b0, uo_out}, 9'h000);
    checkOutput("reset_uio_out", {1'b0, uio_out}, 9'h000);
    checkOutput("uio_oe", {1'b0, uio_oe}, 9'h03C);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pair in, check head, then drain back to empty.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b);
      checkOutput($sformatf("vec%0d_valid", i), {8'h0, uio_out[2]}, 9'h001);
      checkOutput($sformatf("vec%0d_uo", i), {1'b0, uo_out}, {1'b0, vectors[i].exp_uo});
      checkOutput($sformatf("vec%0d_carry", i), {8'h0, uio_out[5]}, {8'h0, vectors[i].exp_carry});
      pulse_read();
      checkOutput($sformatf("vec%0d_drained_valid", i), {8'h0, uio_out[2]}, 9'h000);
      checkOutput($sformatf("vec%0d_drained_uo", i), {1'b0, uo_out}, 9'h000);
    end

    // Overflow: five pushes into a four-deep FIFO with no reads.
    applyStimulus(8'h00, 8'h01);
    applyStimulus(8'h01, 8'h01);
    applyStimulus(8'h01, 8'h02);
    checkOutput("ovf_not_full_at3", {8'h0, uio_out[3]}, 9'h000);
    applyStimulus(8'h02, 8'h02);
    checkOutput("ovf_full_at4", {8'h0, uio_out[3]}, 9'h001);
    checkOutput("ovf_clear_at4", {8'h0, uio_out[4]}, 9'h000);
    applyStimulus(8'h02, 8'h03);
    checkOutput("ovf_set_at5", {8'h0, uio_out[4]}, 9'h001);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), {1'b0, uo_out}, 9'(i));
      pulse_read();
    end
    checkOutput("ovf_empty_valid", {8'h0, uio_out[2]}, 9'h000);
    checkOutput("ovf_sticky", {8'h0, uio_out[4]}, 9'h001);

    do_reset();
    checkOutput("ovf_cleared_by_reset", {8'h0, uio_out[4]}, 9'h000);

    // Full FIFO with a pop landing in the same cycle as the fifth push.
    applyStimulus(8'h00, 8'h01);
    applyStimulus(8'h01, 8'h01);
    applyStimulus(8'h01, 8'h02);
    applyStimulus(8'h02, 8'h02);
    write_byte(8'h02);
    ui_in = 8'h03;
    @(negedge clk);
    wr_strobe = 1'b1;
    @(negedge clk);
    rd_ack = 1'b1;
    repeat (4) @(negedge clk);
    wr_strobe = 1'b0;
    rd_ack    = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("simul_no_ovf", {8'h0, uio_out[4]}, 9'h000);
    checkOutput("simul_full", {8'h0, uio_out[3]}, 9'h001);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("simul_drain%0d", i), {1'b0, uo_out}, 9'(i));
      pulse_read();
    end

    // Reads on an empty FIFO change nothing.
    pulse_read();
    pulse_read();
    checkOutput("empty_rd_uo", {1'b0, uo_out}, 9'h000);
    checkOutput("empty_rd_uio", {1'b0, uio_out}, 9'h000);

    // A long-held strobe must capture only once.
    ui_in = 8'h05;
    @(negedge clk);
    wr_strobe = 1'b1;
    repeat (20) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("hold_no_push", {8'h0, uio_out[2]}, 9'h000);
    write_byte(8'h03);
    checkOutput("hold_sum", {1'b0, uo_out}, 9'h008);
    pulse_read();
    checkOutput("hold_single_entry", {8'h0, uio_out[2]}, 9'h000);

    // Asynchronous reset while in PH_B with two queued results.
    applyStimulus(8'h11, 8'h22);
    applyStimulus(8'h33, 8'h44);
    write_byte(8'h55);
    checkOutput("pre_reset_uo", {1'b0, uo_out}, 9'h033);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_uo", {1'b0, uo_out}, 9'h000);
    checkOutput("async_reset_uio", {1'b0, uio_out}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h10, 8'h20);
    checkOutput("post_reset_sum", {1'b0, uo_out}, 9'h030);
    checkOutput("post_reset_carry", {8'h0, uio_out[5]}, 9'h000);
    pulse_read();
    checkOutput("post_reset_one_entry", {8'h0, uio_out[2]}, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/tt_um_torstencc_sum_drain.md
# tt_um_torstencc_sum_drain

Sequential companion to the team's combinational byte adder tile. It accepts operands A and B as a strobed byte stream on `ui_in`, forms the 9-bit sum in a registered stage, and buffers results in a small FIFO. An external reader drains the FIFO over a valid/ack handshake on the bidirectional pins. It occupies a full Tiny Tapeout user slot and uses the standard `tt_um_` pin set.

## Interface
Parameters:
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, default 2: flops in each control-input synchronizer; ≥2.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  always 1 when powered; ignored.
- `ui_in`  in  8  operand byte; must be held stable from 1 cycle before until SYNC_STAGES+2 cycles after the strobe rises.
- `uio_in`  in  8  [0] `wr_strobe` (async level), [1] `rd_ack` (async level); other bits ignored.
- `uo_out`  out  8  FIFO head sum[7:0] when non-empty, else 0.
- `uio_out`  out  8  [2] `out_valid`, [3] `full`, [4] `overflow` (sticky), [5] head carry sum[8] (0 when empty); other bits 0.
- `uio_oe`  out  8  constant 8'b0011_1100.

## Operation
- `wr_strobe` and `rd_ack` each pass through a SYNC_STAGES synchronizer followed by a rising-edge detector. Each produces a single-cycle event: `wr_ev` and `rd_ev`. Levels held high produce exactly one event.
- Operand FSM, two states:
  - PH_A: on `wr_ev`, capture `ui_in` into `a_reg` and go to PH_B.
  - PH_B: on `wr_ev`, capture `ui_in` as B, load `sum_reg` = {1'b0,a_reg}+{1'b0,B} (9 bits, no truncation), assert `sum_vld` for 1 cycle, and return to PH_A.
- Push: when `sum_vld` is high, write `sum_reg` to the FIFO.
  - If the FIFO is full and there is no simultaneous pop, drop the sum and set `overflow`.
  - `overflow` clears only on reset.
- Pop: `rd_ev` with the FIFO non-empty advances the head. `rd_ev` on an empty FIFO is ignored, with no underflow flag.
- Simultaneous push and pop:
  - Both take effect; the count is unchanged.
  - When full, the pop frees the slot and the push succeeds, so no overflow is raised.
  - When empty, the pop is ignored and the push lands.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. `full` = (count==DEPTH). `out_valid` = (count!=0).
- `uo_out` and `uio_out[5]` are driven combinationally from the head entry, gated to 0 when empty.
- Reset, whether mid-operation or asynchronous, returns to:
  - FSM in PH_A; `a_reg`, `sum_reg` and `sum_vld` cleared.
  - FIFO empty; `overflow` cleared.
  - Synchronizer and edge-detect flops cleared, so a strobe held high through reset release produces one event after release.
  - `uo_out`=0; `uio_out`=0.

## Timing
- A strobe pin first sampled high at edge k produces its event in the cycle after edge k+SYNC_STAGES-1. The capture happens at edge k+SYNC_STAGES, which is E.
- For the B write with event edge E:
  - `sum_reg` is valid after E.
  - FIFO write happens at E+1.
  - `out_valid`, `uo_out` and carry reflect the new head after E+1, provided the FIFO was empty.
- Total latency from the B pin rising to `out_valid` is SYNC_STAGES+2 edges, i.e. 4 with defaults.
- For `rd_ack` with event edge E: the head advances at E, and `out_valid`/`uo_out` update after E.
- Minimum strobe high and low time is SYNC_STAGES+1 cycles each. Shorter pulses may be missed; this is not checked.

## Structure
- Package `torstencc_drain_pkg` holds:
  - pin-index localparams (`WR_STROBE_BIT`=0, `RD_ACK_BIT`=1, `VALID_BIT`=2, `FULL_BIT`=3, `OVF_BIT`=4, `CARRY_BIT`=5);
  - `UIO_OE_MASK`=8'b0011_1100;
  - `typedef enum logic {PH_A, PH_B} phase_t`.
- Sub-module `torstencc_sync_edge` (synchronizer plus rising-edge detector, parameter SYNC_STAGES) is instantiated twice.
- The FIFO is inline in the top module: a register array with head/tail/count.

## Test plan
- Reset, then write A=0x12 and B=0x34 → after 4 edges from the B strobe: `out_valid`=1, `uo_out`=0x46, carry=0.
- A=0xFF, B=0x02 → `uo_out`=0x01, carry=1. Pulse `rd_ack` → `out_valid`=0, `uo_out`=0x00.
- Push 5 pairs with sums 1..5 and no reads (DEPTH=4):
  - after the 4th push: `full`=1;
  - after the 5th push: `overflow`=1 and the FIFO still holds 1,2,3,4;
  - draining 4 times yields 1,2,3,4 in order, then `out_valid`=0 with `overflow` still 1.
- With the FIFO full, time the `rd_ack` event to coincide with the 5th push → `overflow`=0, and the contents become 2,3,4,5.
- `rd_ack` pulses on an empty FIFO → no state change. Hold `wr_strobe` high for 20 cycles → exactly one capture.
- Assert `rst_n`=0 while in PH_B with 2 entries queued → all outputs 0 immediately. After release, the next write is treated as A.
